ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Two-master arbiter for the single-port data RAM (RAM_B: 4 byte write enables, word-addressed).
//  Master 0 is the CPU data path (behind dm_controller/MIO_BUS); master 1 is a debug/DMA loader.
//  Serialises requests, drives the RAM port and returns the read data with a req/ack handshake.
//  Sits between the masters and the RAM; it replaces the direct MIO_BUS->RAM_B connection.
// PARAMETERS
//  ADDR_W      10  RAM word-address width; ram_addr = mX_addr[ADDR_W+1:2]
//  READ_LAT    1   RAM read latency in clocks, legal range 1..3
//  FIXED_PRIO  0   0 = round-robin arbitration; 1 = master 0 always wins ties
// PORTS
//  clk        in   1       rising-edge clock
//  rstn       in   1       asynchronous reset, active low
//  m0_req     in   1       master 0 request; held high until m0_ack
//  m0_we      in   1       1 = write, 0 = read
//  m0_be      in   4       byte enables, used only when m0_we=1
//  m0_addr    in   32      byte address; bits [1:0] and above ADDR_W+1 are ignored
//  m0_wdata   in   32      write data
//  m0_ack     out  1       one-cycle completion pulse
//  m0_rdata   out  32      read data, valid while m0_ack=1
//  m1_*       same as m0_*, for master 1
//  ram_en     out  1       RAM access strobe
//  ram_we     out  4       RAM byte write enables
//  ram_addr   out  ADDR_W  RAM word address
//  ram_din    out  32      RAM write data
//  ram_dout   in   32      RAM read data, valid READ_LAT clocks after the ISSUE cycle
//  busy       out  1       high in any state other than IDLE
//  grant      out  1       id of the master being served; holds its last value in IDLE
// BEHAVIOUR
//  Reset (rstn=0, asynchronous): state=IDLE; all ack, ram_en, ram_we and busy = 0;
//   rdata, ram_addr and ram_din = 0; grant=0; last_grant=1, so master 0 wins the first tie.
//  FSM: IDLE -> ISSUE -> WAIT (reads only, READ_LAT cycles) -> ACK -> IDLE.
//  IDLE: when any req is high, choose the winner and latch its we/be/addr/wdata.
//   - Round-robin: if both requests are high, the master that is not last_grant wins.
//   - FIXED_PRIO=1: master 0 wins any tie.
//   - Next state is ISSUE. With no req, stay in IDLE.
//  ISSUE (exactly 1 cycle): ram_en=1, ram_addr and ram_din from the latched request.
//   - ram_we = be for a write, 4'b0000 for a read.
//   - Next state: WAIT for a read, ACK for a write.
//  WAIT: count READ_LAT cycles; ram_en=0 and ram_we=0 throughout.
//   - Capture ram_dout on the last WAIT edge; next state is ACK.
//  ACK (1 cycle): winner's ack=1; winner's rdata = captured data (reads), previous value (writes).
//   - Loser's ack stays 0. last_grant = winner. Next state is IDLE.
//  Latency from req sampled in IDLE (cycle 0): write ack in cycle 2; read ack in cycle 2+READ_LAT.
//  Throughput: one access per 3 cycles (write) or 3+READ_LAT cycles (read). Back-to-back is allowed:
//   a req still high in IDLE right after ACK is treated as a new request.
//  A master must keep req/we/be/addr/wdata stable until ack. Changes after the IDLE latch are ignored.
//  A req that drops before its grant is never served. A req that drops after latch completes anyway.
//  A write with be=0000 still runs a full ISSUE/ACK sequence with ram_we=0.
//  The losing master waits. Round-robin bounds its wait to one access of the other master.
//  Reset mid-access aborts it immediately: no ack is issued; a write in ISSUE may or may not land.
// TESTING
//  1 Reset: rstn=0 during a read -> all ack=0, ram_en=0, ram_we=0, busy=0 at once; IDLE after release.
//  2 m0 write addr=0x0000_0010, be=0011, wdata=0xA5A5_1234 ->
//    ISSUE: ram_addr=4, ram_we=0011, ram_din=0xA5A5_1234; m0_ack in cycle 2.
//  3 m1 read addr=0x0000_0010, RAM holds 0xDEAD_BEEF, READ_LAT=1 ->
//    m1_ack in cycle 3 with m1_rdata=0xDEAD_BEEF; ram_we=0 throughout.
//  4 m0 and m1 request together, held 4 accesses, FIXED_PRIO=0 -> grant order 0,1,0,1;
//    with FIXED_PRIO=1 -> 0,0,0,0 and m1 is never acked.
//  5 READ_LAT=3 read -> ack at cycle 5; ram_dout changes during the first two WAIT cycles are ignored.
//  6 Address 0xFFFF_F004 -> ram_addr=1, upper bits ignored; write be=0000 -> ram_we=0, ack in cycle 2.

Source files
------------

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// ram_arbiter : two-master req/ack arbiter in front of a single-port word RAM
// Revision    : 1.0
// ============================================================================
module ram_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int READ_LAT   = 1,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rstn,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [3:0]        m0_be,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_ack,
  output logic [31:0]       m0_rdata,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [3:0]        m1_be,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_ack,
  output logic [31:0]       m1_rdata,

  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,

  output logic              busy,
  output logic              grant
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_ACK   = 2'd3;

  localparam logic [1:0] LAT_LAST = 2'(READ_LAT - 1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [1:0]        wait_cnt;
  logic              winner;
  logic              last_grant;
  logic              pick;
  logic              any_req;
  logic              req_we;
  logic [3:0]        req_be;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [31:0]       rdata0;
  logic [31:0]       rdata1;
  logic              unused_addr_bits;

  // Byte-offset and out-of-range address bits are deliberately dropped.
  assign unused_addr_bits = ^{m0_addr[31:ADDR_W+2], m0_addr[1:0],
                              m1_addr[31:ADDR_W+2], m1_addr[1:0]};

  assign any_req = m0_req | m1_req;

  always_comb begin
    pick = 1'b0;
    if (m0_req && m1_req) begin
      pick = FIXED_PRIO ? 1'b0 : ~last_grant;
    end else if (m1_req) begin
      pick = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (any_req) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = req_we ? ST_ACK : ST_WAIT;
      ST_WAIT:  if (wait_cnt == LAT_LAST) state_nxt = ST_ACK;
      ST_ACK:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    ram_en = 1'b0;
    ram_we = 4'b0000;
    m0_ack = 1'b0;
    m1_ack = 1'b0;
    busy   = (state != ST_IDLE);
    case (state)
      ST_ISSUE: begin
        ram_en = 1'b1;
        ram_we = req_we ? req_be : 4'b0000;
      end
      ST_ACK: begin
        m0_ack = ~winner;
        m1_ack = winner;
      end
      default: ;
    endcase
  end

  // Request latch, wait counter and read-data capture
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      winner     <= 1'b0;
      last_grant <= 1'b1;
      req_we     <= 1'b0;
      req_be     <= 4'b0000;
      req_addr   <= '0;
      req_wdata  <= 32'd0;
      wait_cnt   <= 2'd0;
      rdata0     <= 32'd0;
      rdata1     <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            winner    <= pick;
            req_we    <= pick ? m1_we : m0_we;
            req_be    <= pick ? m1_be : m0_be;
            req_addr  <= pick ? m1_addr[ADDR_W+1:2] : m0_addr[ADDR_W+1:2];
            req_wdata <= pick ? m1_wdata : m0_wdata;
          end
        end
        ST_ISSUE: begin
          wait_cnt <= 2'd0;
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt + 2'd1;
          if (wait_cnt == LAT_LAST) begin
            if (winner) begin
              rdata1 <= ram_dout;
            end else begin
              rdata0 <= ram_dout;
            end
          end
        end
        ST_ACK: begin
          last_grant <= winner;
        end
        default: ;
      endcase
    end
  end

  assign ram_addr = req_addr;
  assign ram_din  = req_wdata;
  assign grant    = winner;
  assign m0_rdata = rdata0;
  assign m1_rdata = rdata1;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ram_arbiter : three arbiter configurations against table vectors,
//                  hand sequences and a transaction-level reference model
// ============================================================================
module tb_ram_arbiter;

  localparam int NI = 3;   // 0: RR lat1, 1: fixed prio lat1, 2: RR lat3
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        req0 [NI], req1 [NI], we0 [NI], we1 [NI];
  logic [3:0]  be0  [NI], be1  [NI];
  logic [31:0] addr0[NI], addr1[NI], wd0[NI], wd1[NI];
  logic        ack0 [NI], ack1 [NI];
  logic [31:0] rd0  [NI], rd1  [NI];
  logic        en   [NI];
  logic [3:0]  rwe  [NI];
  logic [AW-1:0] radr [NI];
  logic [31:0] din  [NI], dout [NI];
  logic        busy [NI], grant[NI];

  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [31:0] init_word(int w);
    case (w)
      1:       return 32'h0BAD_F00D;
      2:       return 32'h0000_0000;
      4:       return 32'hDEAD_BEEF;
      default: return 32'(w) * 32'h9E37_79B1;
    endcase
  endfunction

  function automatic int lat_of(int i);
    return (i == 2) ? 3 : 1;
  endfunction

  for (genvar i = 0; i < NI; i++) begin : g_dut
    localparam int L = (i == 2) ? 3 : 1;
    logic [31:0] mem  [1024];
    logic [31:0] pipe [3];

    ram_arbiter #(.ADDR_W(AW), .READ_LAT(L), .FIXED_PRIO(i == 1)) dut (
      .clk(clk), .rstn(rstn),
      .m0_req(req0[i]), .m0_we(we0[i]), .m0_be(be0[i]), .m0_addr(addr0[i]),
      .m0_wdata(wd0[i]), .m0_ack(ack0[i]), .m0_rdata(rd0[i]),
      .m1_req(req1[i]), .m1_we(we1[i]), .m1_be(be1[i]), .m1_addr(addr1[i]),
      .m1_wdata(wd1[i]), .m1_ack(ack1[i]), .m1_rdata(rd1[i]),
      .ram_en(en[i]), .ram_we(rwe[i]), .ram_addr(radr[i]), .ram_din(din[i]),
      .ram_dout(dout[i]), .busy(busy[i]), .grant(grant[i])
    );

    // RAM with L-stage read pipeline; idle slots carry junk
    always @(posedge clk) begin
      if (!rstn) begin
        for (int w = 0; w < 1024; w++) mem[w] <= init_word(w);
      end else if (en[i]) begin
        for (int b = 0; b < 4; b++)
          if (rwe[i][b]) mem[radr[i]][8*b +: 8] <= din[i][8*b +: 8];
      end
      pipe[0] <= en[i] ? mem[radr[i]] : $urandom;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign dout[i] = pipe[L-1];
  end

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[inst %0d]: got %h expected %h", name, inst, act, exp);
  endtask

  task automatic drv(input int i, input int m, input bit r, input bit w,
                     input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      req0[i] = r; we0[i] = w; be0[i] = b; addr0[i] = a; wd0[i] = d;
    end else begin
      req1[i] = r; we1[i] = w; be1[i] = b; addr1[i] = a; wd1[i] = d;
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < NI; i++) begin
      drv(i, 0, 0, 0, 4'h0, 32'h0, 32'h0);
      drv(i, 1, 0, 0, 4'h0, 32'h0, 32'h0);
    end
  endtask

  // Leaves the caller just after a rising edge with the DUTs idle
  task automatic do_reset();
    clear_all();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk({tag, "_busy"},  i, 32'(busy[i]), 32'd0);
      chk({tag, "_ram_en"}, i, 32'(en[i]), 32'd0);
      chk({tag, "_ram_we"}, i, 32'(rwe[i]), 32'd0);
      chk({tag, "_acks"},  i, {30'd0, ack1[i], ack0[i]}, 32'd0);
      chk({tag, "_grant"}, i, 32'(grant[i]), 32'd0);
      chk({tag, "_ram_addr"}, i, 32'(radr[i]), 32'd0);
      chk({tag, "_ram_din"}, i, din[i], 32'd0);
      chk({tag, "_rdata"}, i, rd0[i] | rd1[i], 32'd0);
    end
  endtask

  typedef struct {
    bit          m;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [AW-1:0] e_addr;
    logic [3:0]  e_we;
    logic [31:0] e_rd;
    int          e_ack;    // ack cycle for a single-cycle-latency RAM
  } vec_t;

  vec_t vecs [9];

  task automatic run_vec(input int i, input vec_t v);
    int issue_cyc, ack_cyc, exp_ack;
    logic [3:0] iw;
    logic [AW-1:0] ia;
    logic [31:0] idn, got_rd;
    bit stray_we, other_ack, got_grant;
    issue_cyc = -1; ack_cyc = -1; iw = 0; ia = 0; idn = 0; got_rd = 0;
    stray_we = 0; other_ack = 0; got_grant = 0;
    exp_ack = v.e_ack + (v.we ? 0 : lat_of(i) - 1);
    drv(i, v.m, 1, v.we, v.be, v.addr, v.wd);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (en[i]) begin
        if (issue_cyc < 0) issue_cyc = k;
        iw = rwe[i]; ia = radr[i]; idn = din[i];
      end else if (rwe[i] != 4'h0) stray_we = 1;
      if ((v.m ? ack0[i] : ack1[i]) == 1'b1) other_ack = 1;
      if ((v.m ? ack1[i] : ack0[i]) == 1'b1) begin
        ack_cyc = k;
        got_rd = v.m ? rd1[i] : rd0[i];
        got_grant = grant[i];
      end
      @(posedge clk); #1;
      if (ack_cyc >= 0) break;
    end
    drv(i, v.m, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("vec_ack_cycle", i, 32'(ack_cyc), 32'(exp_ack));
    chk("vec_issue_cycle", i, 32'(issue_cyc), 32'd1);
    chk("vec_ram_addr", i, 32'(ia), 32'(v.e_addr));
    chk("vec_ram_we", i, 32'(iw), 32'(v.e_we));
    if (v.we) chk("vec_ram_din", i, idn, v.wd);
    chk("vec_rdata", i, got_rd, v.e_rd);
    chk("vec_grant", i, 32'(got_grant), 32'(v.m));
    chk("vec_stray_we_or_ack", i, {30'd0, stray_we, other_ack}, 32'd0);
  endtask

  // ---------------- transaction-level reference model ----------------
  bit            mdl_act  [NI];
  int            mdl_start[NI];
  bit            mdl_win  [NI], mdl_last[NI], mdl_grant[NI];
  bit            mdl_we   [NI];
  logic [3:0]    mdl_be   [NI];
  logic [AW-1:0] mdl_adr  [NI];
  logic [31:0]   mdl_wd   [NI];
  logic [31:0]   mdl_rd   [NI][2];
  logic [31:0]   ref_mem  [NI][1024];
  bit            sa0 [NI], sa1 [NI];

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      mdl_act[i] = 0; mdl_start[i] = 0; mdl_win[i] = 0; mdl_last[i] = 1;
      mdl_grant[i] = 0; mdl_we[i] = 0; mdl_be[i] = 0; mdl_adr[i] = 0; mdl_wd[i] = 0;
      mdl_rd[i][0] = 0; mdl_rd[i][1] = 0; sa0[i] = 0; sa1[i] = 0;
      for (int w = 0; w < 1024; w++) ref_mem[i][w] = init_word(w);
    end
  endtask

  task automatic drive_rand(input int i, input int m, input bit seen);
    logic [31:0] r;
    int w;
    bit cur;
    cur = (m == 0) ? req0[i] : req1[i];
    if (!cur || seen) begin
      if ($urandom_range(0, 2) == 0) begin
        r = $urandom;
        w = ($urandom_range(0, 9) == 0) ? 1023 : $urandom_range(0, 7);
        drv(i, m, 1, r[5], 4'($urandom), {r[31:12], 10'(w), r[1:0]}, $urandom);
      end else begin
        drv(i, m, 0, 0, 4'h0, 32'h0, 32'h0);
      end
    end else if ($urandom_range(0, 19) == 0) begin
      drv(i, m, 0, 0, 4'h0, 32'h0, 32'h0);
    end
  endtask

  task automatic model_check(input int i, input int t);
    logic [3:0] e_we;
    bit e_en, e_busy, e_a0, e_a1, e_grant, do_issue, nw, done_now;
    int off, fin;
    e_we = 0; e_en = 0; e_busy = 0; e_a0 = 0; e_a1 = 0; do_issue = 0; done_now = 0;
    e_grant = mdl_grant[i]; off = 0; fin = 0;
    if (mdl_act[i]) begin
      off = t - mdl_start[i];
      fin = mdl_we[i] ? 2 : 2 + lat_of(i);
      e_busy = 1;
      if (off == 1) begin
        e_en = 1; do_issue = 1;
        e_we = mdl_we[i] ? mdl_be[i] : 4'h0;
        if (mdl_we[i])
          for (int b = 0; b < 4; b++)
            if (mdl_be[i][b]) ref_mem[i][mdl_adr[i]][8*b +: 8] = mdl_wd[i][8*b +: 8];
      end
      if (off == fin) begin
        done_now = 1;
        if (!mdl_we[i]) mdl_rd[i][mdl_win[i]] = ref_mem[i][mdl_adr[i]];
        if (mdl_win[i]) e_a1 = 1; else e_a0 = 1;
      end
    end
    chk("rnd_busy", i, 32'(busy[i]), 32'(e_busy));
    chk("rnd_ram_en", i, 32'(en[i]), 32'(e_en));
    chk("rnd_ram_we", i, 32'(rwe[i]), 32'(e_we));
    chk("rnd_ack0", i, 32'(ack0[i]), 32'(e_a0));
    chk("rnd_ack1", i, 32'(ack1[i]), 32'(e_a1));
    chk("rnd_grant", i, 32'(grant[i]), 32'(e_grant));
    if (do_issue) begin
      chk("rnd_ram_addr", i, 32'(radr[i]), 32'(mdl_adr[i]));
      chk("rnd_ram_din", i, din[i], mdl_wd[i]);
    end
    if (e_a0) chk("rnd_rdata0", i, rd0[i], mdl_rd[i][0]);
    if (e_a1) chk("rnd_rdata1", i, rd1[i], mdl_rd[i][1]);
    if (done_now) begin
      mdl_act[i] = 0;
      mdl_last[i] = mdl_win[i];
    end else if (!mdl_act[i] && (req0[i] || req1[i])) begin
      if (req0[i] && req1[i]) nw = (i == 1) ? 1'b0 : !mdl_last[i];
      else nw = req1[i];
      mdl_win[i] = nw; mdl_grant[i] = nw;
      mdl_we[i]  = nw ? we1[i] : we0[i];
      mdl_be[i]  = nw ? be1[i] : be0[i];
      mdl_adr[i] = nw ? addr1[i][AW+1:2] : addr0[i][AW+1:2];
      mdl_wd[i]  = nw ? wd1[i] : wd0[i];
      mdl_start[i] = t; mdl_act[i] = 1;
    end
    sa0[i] = ack0[i];
    sa1[i] = ack1[i];
  endtask

  initial begin
    int ord  [NI][4];
    int acyc [NI][4];
    int nack [NI];
    int m1acks [NI];
    logic [3:0] code;

    vecs[0] = '{1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0,         10'd4,     4'h0, 32'hDEAD_BEEF, 3};
    vecs[1] = '{1'b0, 1'b1, 4'h3, 32'h0000_0010, 32'hA5A5_1234, 10'd4,     4'h3, 32'h0000_0000, 2};
    vecs[2] = '{1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0,         10'd4,     4'h0, 32'hDEAD_1234, 3};
    vecs[3] = '{1'b0, 1'b1, 4'h0, 32'hFFFF_F004, 32'h5555_5555, 10'd1,     4'h0, 32'h0000_0000, 2};
    vecs[4] = '{1'b0, 1'b0, 4'h0, 32'hFFFF_F004, 32'h0,         10'd1,     4'h0, 32'h0BAD_F00D, 3};
    vecs[5] = '{1'b1, 1'b1, 4'h8, 32'h0000_0008, 32'hAABB_CCDD, 10'd2,     4'h8, 32'hDEAD_1234, 2};
    vecs[6] = '{1'b0, 1'b0, 4'h0, 32'h0000_0008, 32'h0,         10'd2,     4'h0, 32'hAA00_0000, 3};
    vecs[7] = '{1'b1, 1'b1, 4'hF, 32'h0000_3FFC, 32'h1234_5678, 10'h3FF,   4'hF, 32'hDEAD_1234, 2};
    vecs[8] = '{1'b0, 1'b0, 4'h0, 32'hABCD_3FFC, 32'h0,         10'h3FF,   4'h0, 32'h1234_5678, 3};

    rstn = 1'b1;
    clear_all();
    #2;
    do_reset();
    @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk); #1;

    // Reset asserted in the middle of a read
    for (int i = 0; i < NI; i++) drv(i, 0, 1, 0, 4'h0, 32'h0000_0010, 32'h0);
    repeat (2) begin @(posedge clk); #1; end
    #2 rstn = 1'b0;
    #1 chk_reset_vals("mid_read_reset");
    clear_all();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++)
        chk("post_reset_idle", i, {29'd0, busy[i], ack1[i], ack0[i]}, 32'd0);
    end
    @(posedge clk); #1;

    for (int i = 0; i < NI; i++) begin
      do_reset();
      foreach (vecs[v]) run_vec(i, vecs[v]);
    end

    // Both masters held high for several back-to-back writes
    do_reset();
    for (int i = 0; i < NI; i++) begin
      drv(i, 0, 1, 1, 4'hF, 32'h0000_0100, 32'h1111_0000);
      drv(i, 1, 1, 1, 4'hF, 32'h0000_0200, 32'h2222_0000);
      nack[i] = 0; m1acks[i] = 0;
      for (int j = 0; j < 4; j++) begin ord[i][j] = -1; acyc[i][j] = -1; end
    end
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (ack0[i] || ack1[i]) begin
          if (nack[i] < 4) begin
            ord[i][nack[i]] = ack1[i] ? 1 : 0;
            acyc[i][nack[i]] = k;
          end
          nack[i]++;
        end
        if (ack1[i]) m1acks[i]++;
      end
      @(posedge clk); #1;
    end
    clear_all();
    for (int i = 0; i < NI; i++) begin
      code = 4'h0;
      for (int j = 0; j < 4; j++) code[j] = (ord[i][j] == 1);
      chk("arb_order", i, 32'(code), (i == 1) ? 32'h0 : 32'hA);
      for (int j = 0; j < 4; j++) chk("arb_ack_cycle", i, 32'(acyc[i][j]), 32'(2 + 3*j));
      if (i == 1) chk("fixed_prio_m1_starved", i, 32'(m1acks[i]), 32'd0);
    end
    repeat (2) begin @(posedge clk); #1; end

    // Randomised traffic against the reference model
    do_reset();
    model_reset();
    for (int t = 0; t < 2000; t++) begin
      for (int i = 0; i < NI; i++) begin
        drive_rand(i, 0, sa0[i]);
        drive_rand(i, 1, sa1[i]);
      end
      @(negedge clk);
      for (int i = 0; i < NI; i++) model_check(i, t);
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
